// File: rtl/dmem_arb_pkg.sv
// Shared types and default widths for the data-memory arbiter.
package dmem_arb_pkg;

   localparam int DEF_ADDR_W = 8;
   localparam int DEF_DATA_W = 16;

   typedef enum logic {
      IDLE     = 1'b0,
      DMA_LOCK = 1'b1
   } arb_state_e;

   typedef enum logic {
      OWN_CPU = 1'b0,
      OWN_DMA = 1'b1
   } owner_e;

endpackage

// File: rtl/dmem_arb_if.sv
// One requester port of the data-memory arbiter (CPU or DMA side).
interface dmem_arb_if
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
);
   logic              req;
   logic              wr;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              gnt;
   logic              rvalid;
   logic [DATA_W-1:0] rdata;

   modport master (
      output req, wr, addr, wdata,
      input  gnt, rvalid, rdata
   );

   modport slave (
      input  req, wr, addr, wdata,
      output gnt, rvalid, rdata
   );
endinterface

// File: rtl/dmem_arb_mux.sv
// Combinational port-to-RAM mux: forwards the granted port, drives zeros otherwise.
module dmem_arb_mux
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  owner_e            sel_i,
   input  logic              gnt_i,
   input  logic              cpu_wr_i,
   input  logic [ADDR_W-1:0] cpu_addr_i,
   input  logic [DATA_W-1:0] cpu_wdata_i,
   input  logic              dma_wr_i,
   input  logic [ADDR_W-1:0] dma_addr_i,
   input  logic [DATA_W-1:0] dma_wdata_i,
   output logic              mem_en_o,
   output logic              mem_wr_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o
);

   always_comb begin
      mem_en_o    = 1'b0;
      mem_wr_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      if (gnt_i) begin
         mem_en_o = 1'b1;
         if (sel_i == OWN_DMA) begin
            mem_wr_o    = dma_wr_i;
            mem_addr_o  = dma_addr_i;
            mem_wdata_o = dma_wdata_i;
         end else begin
            mem_wr_o    = cpu_wr_i;
            mem_addr_o  = cpu_addr_i;
            mem_wdata_o = cpu_wdata_i;
         end
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// CPU/DMA arbiter for the single-ported data RAM with bounded locked DMA bursts.
// DMEM_ARB_RR_EN: round-robin on IDLE contention; undefined gives fixed CPU priority.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int MAX_BURST = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   dmem_arb_if.slave         cpu,
   dmem_arb_if.slave         dma,
   input  logic              dma_last_i,
   output logic              cpu_stall_o,
   output logic              mem_en_o,
   output logic              mem_wr_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i
);

   localparam int BEAT_W = (MAX_BURST < 2) ? 1 : $clog2(MAX_BURST + 1);
   localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(MAX_BURST);
   localparam bit LOCK_EN = (MAX_BURST > 1);

   arb_state_e        state_q, state_d;
   logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
   owner_e            last_owner_q, last_owner_d;
   logic              cpu_prio_q, cpu_prio_d;
   logic              cpu_rvalid_q, cpu_rvalid_d;
   logic              dma_rvalid_q, dma_rvalid_d;

   logic              cpu_gnt;
   logic              dma_gnt;
   logic              cpu_first;
   logic              policy_cpu;
   logic [BEAT_W-1:0] beat_inc;
   owner_e            mux_sel;

`ifdef DMEM_ARB_RR_EN
   assign policy_cpu = (last_owner_q == OWN_DMA);
`else
   logic unused_owner;
   assign policy_cpu   = 1'b1;
   assign unused_owner = last_owner_q;
`endif

   // The CPU always wins the first IDLE cycle after a lock, whatever the policy.
   assign cpu_first = cpu_prio_q | policy_cpu;
   assign beat_inc  = beat_cnt_q + BEAT_W'(1);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         beat_cnt_q   <= '0;
         last_owner_q <= OWN_DMA;
         cpu_prio_q   <= 1'b0;
         cpu_rvalid_q <= 1'b0;
         dma_rvalid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         beat_cnt_q   <= beat_cnt_d;
         last_owner_q <= last_owner_d;
         cpu_prio_q   <= cpu_prio_d;
         cpu_rvalid_q <= cpu_rvalid_d;
         dma_rvalid_q <= dma_rvalid_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d      = state_q;
      beat_cnt_d   = beat_cnt_q;
      last_owner_d = last_owner_q;
      cpu_prio_d   = 1'b0;
      cpu_rvalid_d = cpu_gnt & ~cpu.wr;
      dma_rvalid_d = dma_gnt & ~dma.wr;

      if (cpu_gnt) begin
         last_owner_d = OWN_CPU;
      end else if (dma_gnt) begin
         last_owner_d = OWN_DMA;
      end

      unique case (state_q)
         IDLE: begin
            if (dma_gnt && !dma_last_i && LOCK_EN) begin
               state_d    = DMA_LOCK;
               beat_cnt_d = BEAT_W'(1);
            end
         end
         DMA_LOCK: begin
            if (!dma_gnt || dma_last_i || (beat_inc == BEAT_MAX)) begin
               state_d    = IDLE;
               beat_cnt_d = '0;
               cpu_prio_d = 1'b1;
            end else begin
               beat_cnt_d = beat_inc;
            end
         end
         default: begin
            state_d    = IDLE;
            beat_cnt_d = '0;
         end
      endcase
   end

   // Output logic: grants are combinational so an uncontended request issues at once
   always_comb begin
      cpu_gnt = 1'b0;
      dma_gnt = 1'b0;
      if (rst_n) begin
         unique case (state_q)
            IDLE: begin
               if (cpu.req && dma.req) begin
                  cpu_gnt = cpu_first;
                  dma_gnt = ~cpu_first;
               end else begin
                  cpu_gnt = cpu.req;
                  dma_gnt = dma.req;
               end
            end
            DMA_LOCK: dma_gnt = dma.req;
            default: begin
               cpu_gnt = 1'b0;
               dma_gnt = 1'b0;
            end
         endcase
      end
   end

   assign mux_sel     = dma_gnt ? OWN_DMA : OWN_CPU;
   assign cpu.gnt     = cpu_gnt;
   assign dma.gnt     = dma_gnt;
   assign cpu_stall_o = cpu.req & ~cpu_gnt;
   assign cpu.rvalid  = cpu_rvalid_q;
   assign dma.rvalid  = dma_rvalid_q;
   assign cpu.rdata   = mem_rdata_i;
   assign dma.rdata   = mem_rdata_i;

   dmem_arb_mux #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_mux (
      .sel_i       (mux_sel),
      .gnt_i       (cpu_gnt | dma_gnt),
      .cpu_wr_i    (cpu.wr),
      .cpu_addr_i  (cpu.addr),
      .cpu_wdata_i (cpu.wdata),
      .dma_wr_i    (dma.wr),
      .dma_addr_i  (dma.addr),
      .dma_wdata_i (dma.wdata),
      .mem_en_o    (mem_en_o),
      .mem_wr_o    (mem_wr_o),
      .mem_addr_o  (mem_addr_o),
      .mem_wdata_o (mem_wdata_o)
   );

`ifndef SYNTHESIS
   a_one_gnt : assert property (@(posedge clk) disable iff (!rst_n) !(cpu_gnt && dma_gnt));
   a_beat_bound : assert property (@(posedge clk) disable iff (!rst_n) beat_cnt_q < BEAT_MAX || MAX_BURST < 2);
   a_lock_no_cpu : assert property (@(posedge clk) disable iff (!rst_n) (state_q == DMA_LOCK) |-> !cpu_gnt);
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: vector table plus hand sequences for burst, exit and reset cases.
`timescale 1ns/1ps
module tb_dmem_arbiter;
   import dmem_arb_pkg::*;

   localparam int AW = 8;
   localparam int DW = 16;
   localparam int MB = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          dma_last;
   logic          cpu_stall;
   logic          mem_en;
   logic          mem_wr;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata = '0;
   logic [DW-1:0] ram [0:255];

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   dmem_arb_if #(.ADDR_W(AW), .DATA_W(DW)) cpu_if ();
   dmem_arb_if #(.ADDR_W(AW), .DATA_W(DW)) dma_if ();

   dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cpu         (cpu_if),
      .dma         (dma_if),
      .dma_last_i  (dma_last),
      .cpu_stall_o (cpu_stall),
      .mem_en_o    (mem_en),
      .mem_wr_o    (mem_wr),
      .mem_addr_o  (mem_addr),
      .mem_wdata_o (mem_wdata),
      .mem_rdata_i (mem_rdata)
   );

   // Behavioural single-port RAM with one-cycle registered read
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_wr) ram[mem_addr] <= mem_wdata;
         else        mem_rdata <= ram[mem_addr];
      end
   end

   typedef struct {
      logic       c_req;
      logic       c_wr;
      logic [7:0] c_addr;
      logic       d_req;
      logic       d_wr;
      logic       d_last;
      logic [7:0] d_addr;
      logic       e_cg;
      logic       e_dg;
      logic       e_crv;
      logic       e_drv;
      logic [15:0] e_rd;
   } vec_t;

   vec_t vecs [12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic c_req, input logic c_wr, input logic [7:0] c_addr,
                        input logic d_req, input logic d_wr, input logic d_last,
                        input logic [7:0] d_addr);
      cpu_if.req   = c_req;
      cpu_if.wr    = c_wr;
      cpu_if.addr  = c_addr;
      cpu_if.wdata = {8'hC0, c_addr};
      dma_if.req   = d_req;
      dma_if.wr    = d_wr;
      dma_if.addr  = d_addr;
      dma_if.wdata = {8'hD0, d_addr};
      dma_last     = d_last;
   endtask

   // One clock: drive inputs after falling edge, check grants, then check read return.
   task automatic cyc(input string tag,
                      input logic c_req, input logic c_wr, input logic [7:0] c_addr,
                      input logic d_req, input logic d_wr, input logic d_last,
                      input logic [7:0] d_addr,
                      input logic e_cg, input logic e_dg,
                      input logic e_crv, input logic e_drv, input logic [15:0] e_rd);
      logic [7:0]  ea;
      logic [15:0] ewd;
      logic        ewr;
      @(negedge clk);
      drive(c_req, c_wr, c_addr, d_req, d_wr, d_last, d_addr);
      #1;
      ea  = e_cg ? c_addr : (e_dg ? d_addr : 8'h00);
      ewd = e_cg ? {8'hC0, c_addr} : (e_dg ? {8'hD0, d_addr} : 16'h0000);
      ewr = e_cg ? c_wr : (e_dg ? d_wr : 1'b0);
      chk({tag, ".cpu_gnt"},   cpu_if.gnt, e_cg);
      chk({tag, ".dma_gnt"},   dma_if.gnt, e_dg);
      chk({tag, ".cpu_stall"}, cpu_stall, c_req & ~e_cg);
      chk({tag, ".mem_en"},    mem_en, e_cg | e_dg);
      chk({tag, ".mem_addr"},  mem_addr, ea);
      chk({tag, ".mem_wr"},    mem_wr, ewr);
      chk({tag, ".mem_wdata"}, mem_wdata, ewd);
      @(posedge clk);
      #1;
      chk({tag, ".cpu_rvalid"}, cpu_if.rvalid, e_crv);
      chk({tag, ".dma_rvalid"}, dma_if.rvalid, e_drv);
      if (e_crv) chk({tag, ".cpu_rdata"}, cpu_if.rdata, e_rd);
      if (e_drv) chk({tag, ".dma_rdata"}, dma_if.rdata, e_rd);
      $display("%s: cgnt=%b dgnt=%b addr=%h crv=%b drv=%b rdata=%h",
               tag, e_cg, e_dg, ea, cpu_if.rvalid, dma_if.rvalid, cpu_if.rdata);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) ram[i] = 16'h5A00 | 16'(i);
      ram[8'h10] = 16'hBEEF;

      // Contention first, so the round-robin start after reset is observable
`ifdef DMEM_ARB_RR_EN
      vecs[0]  = '{1'b1, 1'b0, 8'h12, 1'b1, 1'b0, 1'b1, 8'h13, 1'b1, 1'b0, 1'b1, 1'b0, 16'h5A12};
      vecs[1]  = '{1'b1, 1'b0, 8'h12, 1'b1, 1'b0, 1'b1, 8'h13, 1'b0, 1'b1, 1'b0, 1'b1, 16'h5A13};
      vecs[2]  = '{1'b1, 1'b0, 8'h12, 1'b1, 1'b0, 1'b1, 8'h13, 1'b1, 1'b0, 1'b1, 1'b0, 16'h5A12};
      vecs[3]  = '{1'b1, 1'b0, 8'h12, 1'b1, 1'b0, 1'b1, 8'h13, 1'b0, 1'b1, 1'b0, 1'b1, 16'h5A13};
`else
      vecs[0]  = '{1'b1, 1'b0, 8'h12, 1'b1, 1'b0, 1'b1, 8'h13, 1'b1, 1'b0, 1'b1, 1'b0, 16'h5A12};
      vecs[1]  = '{1'b1, 1'b0, 8'h12, 1'b1, 1'b0, 1'b1, 8'h13, 1'b1, 1'b0, 1'b1, 1'b0, 16'h5A12};
      vecs[2]  = '{1'b1, 1'b0, 8'h12, 1'b1, 1'b0, 1'b1, 8'h13, 1'b1, 1'b0, 1'b1, 1'b0, 16'h5A12};
      vecs[3]  = '{1'b1, 1'b0, 8'h12, 1'b1, 1'b0, 1'b1, 8'h13, 1'b1, 1'b0, 1'b1, 1'b0, 16'h5A12};
`endif
      vecs[4]  = '{1'b1, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 16'hBEEF};
      vecs[5]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
      vecs[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 1'b1, 16'h5A11};
      vecs[7]  = '{1'b1, 1'b1, 8'h30, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000};
      vecs[8]  = '{1'b1, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 16'hC030};
      vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h31, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000};
      vecs[10] = '{1'b1, 1'b0, 8'h31, 1'b1, 1'b0, 1'b1, 8'h32, 1'b1, 1'b0, 1'b1, 1'b0, 16'hD031};
      vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h32, 1'b0, 1'b1, 1'b0, 1'b1, 16'h5A32};

      // Reset state, with a CPU request pending
      drive(1'b1, 1'b1, 8'h12, 1'b1, 1'b0, 1'b0, 8'h13);
      #2;
      chk("rst.cpu_gnt",    cpu_if.gnt, 1'b0);
      chk("rst.dma_gnt",    dma_if.gnt, 1'b0);
      chk("rst.cpu_stall",  cpu_stall, 1'b1);
      chk("rst.mem_en",     mem_en, 1'b0);
      chk("rst.mem_wr",     mem_wr, 1'b0);
      chk("rst.mem_addr",   mem_addr, 8'h00);
      chk("rst.mem_wdata",  mem_wdata, 16'h0000);
      chk("rst.cpu_rvalid", cpu_if.rvalid, 1'b0);
      chk("rst.dma_rvalid", dma_if.rvalid, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
      rst_n = 1'b1;

      for (int i = 0; i < 12; i++) begin
         cyc($sformatf("vec%0d", i), vecs[i].c_req, vecs[i].c_wr, vecs[i].c_addr,
             vecs[i].d_req, vecs[i].d_wr, vecs[i].d_last, vecs[i].d_addr,
             vecs[i].e_cg, vecs[i].e_dg, vecs[i].e_crv, vecs[i].e_drv, vecs[i].e_rd);
      end

      // 6-beat write burst capped at MAX_BURST, CPU waiting from beat 2
      cyc("burst0", 0, 0, 8'h00, 1, 1, 0, 8'h20, 0, 1, 0, 0, 16'h0);
      cyc("burst1", 1, 0, 8'h40, 1, 1, 0, 8'h21, 0, 1, 0, 0, 16'h0);
      cyc("burst2", 1, 0, 8'h40, 1, 1, 0, 8'h22, 0, 1, 0, 0, 16'h0);
      cyc("burst3", 1, 0, 8'h40, 1, 1, 0, 8'h23, 0, 1, 0, 0, 16'h0);
      cyc("burst4", 1, 0, 8'h40, 1, 1, 0, 8'h24, 1, 0, 1, 0, 16'h5A40);
      cyc("burst5", 0, 0, 8'h00, 1, 1, 0, 8'h24, 0, 1, 0, 0, 16'h0);
      cyc("burst6", 0, 0, 8'h00, 1, 1, 1, 8'h25, 0, 1, 0, 0, 16'h0);
      cyc("burst7", 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0, 16'h0);
      chk("burst.ram20", ram[8'h20], 16'hD020);
      chk("burst.ram23", ram[8'h23], 16'hD023);
      chk("burst.ram24", ram[8'h24], 16'hD024);
      chk("burst.ram25", ram[8'h25], 16'hD025);

      // Early dma_last on beat 2, then a fresh burst must get all MAX_BURST beats
      cyc("last0", 0, 0, 8'h00, 1, 1, 0, 8'h50, 0, 1, 0, 0, 16'h0);
      cyc("last1", 1, 0, 8'h41, 1, 1, 1, 8'h51, 0, 1, 0, 0, 16'h0);
      cyc("last2", 1, 0, 8'h41, 1, 1, 1, 8'h52, 1, 0, 1, 0, 16'h5A41);
      cyc("last3", 0, 0, 8'h00, 1, 1, 1, 8'h52, 0, 1, 0, 0, 16'h0);
      cyc("last4", 0, 0, 8'h00, 1, 1, 0, 8'h53, 0, 1, 0, 0, 16'h0);
      cyc("last5", 1, 0, 8'h42, 1, 1, 0, 8'h54, 0, 1, 0, 0, 16'h0);
      cyc("last6", 1, 0, 8'h42, 1, 1, 0, 8'h55, 0, 1, 0, 0, 16'h0);
      cyc("last7", 1, 0, 8'h42, 1, 1, 0, 8'h56, 0, 1, 0, 0, 16'h0);
      cyc("last8", 1, 0, 8'h42, 1, 1, 1, 8'h57, 1, 0, 1, 0, 16'h5A42);
      cyc("last9", 0, 0, 8'h00, 1, 1, 1, 8'h57, 0, 1, 0, 0, 16'h0);

      // dma_req drops mid-lock: no grant that cycle, CPU wins the next
      cyc("drop0", 0, 0, 8'h00, 1, 0, 0, 8'h60, 0, 1, 0, 1, 16'h5A60);
      cyc("drop1", 1, 0, 8'h43, 0, 0, 0, 8'h00, 0, 0, 0, 0, 16'h0);
      cyc("drop2", 1, 0, 8'h43, 1, 0, 1, 8'h61, 1, 0, 1, 0, 16'h5A43);
      cyc("drop3", 0, 0, 8'h00, 1, 0, 1, 8'h61, 0, 1, 0, 1, 16'h5A61);

      // Reset asserted mid-lock with a DMA read outstanding
      cyc("rlk0", 0, 0, 8'h00, 1, 0, 0, 8'h70, 0, 1, 0, 1, 16'h5A70);
      @(negedge clk);
      drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h71);
      #1;
      chk("rlk1.dma_gnt", dma_if.gnt, 1'b1);
      rst_n = 1'b0;
      cpu_if.req = 1'b1;
      #1;
      chk("rlk1.rst_dma_gnt",    dma_if.gnt, 1'b0);
      chk("rlk1.rst_cpu_gnt",    cpu_if.gnt, 1'b0);
      chk("rlk1.rst_cpu_stall",  cpu_stall, 1'b1);
      chk("rlk1.rst_mem_en",     mem_en, 1'b0);
      chk("rlk1.rst_dma_rvalid", dma_if.rvalid, 1'b0);
      @(posedge clk);
      #1;
      chk("rlk2.dma_rvalid", dma_if.rvalid, 1'b0);
      chk("rlk2.cpu_rvalid", cpu_if.rvalid, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      $display("rlk2: reset released");
      cyc("rlk3", 1, 0, 8'h44, 1, 0, 0, 8'h71, 1, 0, 1, 0, 16'h5A44);
      cyc("rlk4", 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0, 16'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running want finished");
      $fatal(1, "timeout");
   end

endmodule
